// File: rtl/pwm_capture_if.sv
// Register bus bundle for pwm_capture: valid/ready request with a one-cycle
// acknowledge, byte address, write data and read data.
interface pwm_capture_if;
    logic        valid_i;
    logic        ready_o;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (
        output valid_i, we_i, addr_i, wdata_i,
        input  ready_o, rdata_o
    );

    modport slave (
        input  valid_i, we_i, addr_i, wdata_i,
        output ready_o, rdata_o
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: bus-mapped PWM input capture channel.
// Measures period (rise to rise) and high time (rise to fall) of an external
// PWM input in prescaled ticks, and flags each completed measurement.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN inserts a 4-sample
// agreement filter after the synchronizer (pulses under 4 clocks ignored).
module pwm_capture #(
    parameter int BITS       = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    pwm_capture_if.slave bus,
    input  logic         cio_pwm_i,
    output logic         irq_o
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_HIGH_SEEN = 2'd2
    } state_t;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_PERIOD   = 3'd2;
    localparam logic [2:0] A_HIGH     = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    // ------------------------------------------------------------------
    // Input path: synchronizer, optional filter, edge detector
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, prev_q;
    logic level;
    logic rise, fall;

    // Two-flop synchronizer plus the previous-level register for edges
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= cio_pwm_i;
            sync2_q <= sync1_q;
            prev_q  <= level;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [2:0] shift_q;
    logic       filt_q, filt_d;

    // Filtered level follows the input only once four samples agree
    always_comb begin
        filt_d = filt_q;
        if (&{sync2_q, shift_q}) begin
            filt_d = 1'b1;
        end else if (~|{sync2_q, shift_q}) begin
            filt_d = 1'b0;
        end
    end

    // Sample history and held filter output
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shift_q <= 3'b000;
            filt_q  <= 1'b0;
        end else begin
            shift_q <= {shift_q[1:0], sync2_q};
            filt_q  <= filt_d;
        end
    end

    assign level = filt_d;
`else
    assign level = sync2_q;
`endif

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       ready_q, ready_d;
    logic [2:0] reg_sel;
    logic       wr_en, wr_ctrl, wr_pre, wr_stat;
    logic       unused_bits;

    assign reg_sel = bus.addr_i[4:2];
    // A write takes effect on the edge that closes the acknowledge cycle
    assign wr_en   = ready_q & bus.valid_i & bus.we_i;
    assign wr_ctrl = wr_en & (reg_sel == A_CTRL);
    assign wr_pre  = wr_en & (reg_sel == A_PRESCALE);
    assign wr_stat = wr_en & (reg_sel == A_STATUS);
    assign ready_d = bus.valid_i & ~ready_q;
    assign unused_bits = ^{bus.addr_i[31:5], bus.addr_i[1:0], bus.wdata_i};

    // ------------------------------------------------------------------
    // Configuration, flags and results
    // ------------------------------------------------------------------
    logic                  en_q, irq_en_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [BITS-1:0]       period_q, period_d;
    logic [BITS-1:0]       high_q, high_d;
    logic                  valid_q, valid_d, ovf_q, ovf_d;
    logic                  irq_q;
    logic                  cap_set, ovf_set;

    // Hardware set wins over a same-cycle write-one-to-clear
    assign valid_d = cap_set | (valid_q & ~(wr_stat & bus.wdata_i[0]));
    assign ovf_d   = ovf_set | (ovf_q & ~(wr_stat & bus.wdata_i[1]));

    // Bus-visible registers, acknowledge and registered interrupt
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ready_q    <= 1'b0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_en_q & (valid_q | ovf_q);
            if (wr_ctrl) begin
                en_q     <= bus.wdata_i[0];
                irq_en_q <= bus.wdata_i[1];
            end
            if (wr_pre) begin
                prescale_q <= bus.wdata_i[PRESCALE_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Measurement state machine
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [BITS-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [BITS-1:0]       hi_shadow_q, hi_shadow_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tick, cnt_max, kill;

    assign tick    = (pre_cnt_q == prescale_q);
    assign cnt_max = &cnt_q;
    // Value including this cycle's tick, so an edge coinciding with a tick
    // still counts that tick
    assign cnt_inc = cnt_q + BITS'(tick);
    // Disabled, or being disabled by a write on this edge
    assign kill    = ~en_q | (wr_ctrl & ~bus.wdata_i[0]);

    // Next-state, counter and capture logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_shadow_d = hi_shadow_q;
        period_d    = period_q;
        high_d      = high_q;
        cap_set     = 1'b0;
        ovf_set     = 1'b0;
        // Prescaler restarts on every rise so ticks are phase-aligned to it
        if (rise || tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
        end

        if (kill) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pre_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (tick && cnt_max) begin
                        ovf_set = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rise) begin
                        // High the whole period: restart without capturing
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (fall) begin
                            hi_shadow_d = cnt_inc;
                            state_d     = ST_HIGH_SEEN;
                        end
                    end
                end
                ST_HIGH_SEEN: begin
                    if (tick && cnt_max) begin
                        ovf_set = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rise) begin
                        period_d = cnt_inc;
                        high_d   = hi_shadow_q;
                        cap_set  = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_ARMED;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counters and high-time shadow
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_shadow_q <= '0;
            pre_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_shadow_q <= hi_shadow_d;
            pre_cnt_q   <= pre_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read data: only driven during the acknowledge cycle
    // ------------------------------------------------------------------
    logic [31:0] rdata_d;

    // Register read multiplexer
    always_comb begin
        rdata_d = 32'd0;
        if (ready_q) begin
            case (reg_sel)
                A_CTRL:     rdata_d = {30'd0, irq_en_q, en_q};
                A_PRESCALE: rdata_d = 32'(prescale_q);
                A_PERIOD:   rdata_d = 32'(period_q);
                A_HIGH:     rdata_d = 32'(high_q);
                A_STATUS:   rdata_d = {29'd0, level, ovf_q, valid_q};
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.rdata_o = rdata_d;
    assign irq_o       = irq_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (BITS=8 so overflow is reachable).
`timescale 1ns/1ps
module tb_pwm_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm = 1'b0;
    logic irq;

    pwm_capture_if bus ();

    pwm_capture #(
        .BITS       (8),
        .PRESCALE_W (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus),
        .cio_pwm_i (pwm),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FD = 3;
`else
    localparam int FD = 0;
`endif

    localparam logic [31:0] R_CTRL   = 32'h00;
    localparam logic [31:0] R_PRE    = 32'h04;
    localparam logic [31:0] R_PERIOD = 32'h08;
    localparam logic [31:0] R_HIGH   = 32'h0C;
    localparam logic [31:0] R_STATUS = 32'h10;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("[%0t] check %-14s observed 0x%0h expected 0x%0h", $time, tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdat);
        int waited;
        waited = 0;
        bus.valid_i = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wd;
        cyc(1);
        while (bus.ready_o !== 1'b1 && waited < 8) begin
            cyc(1);
            waited++;
        end
        if (bus.ready_o !== 1'b1) begin
            check("bus_timeout", {31'd0, bus.ready_o}, 32'd1);
            rdat = 'x;
        end else begin
            rdat = bus.rdata_o;
        end
        cyc(1);
        bus.valid_i = 1'b0;
        bus.we_i    = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_op(1'b1, addr, wd, dummy);
    endtask

    task automatic rdreg(input logic [31:0] addr, output logic [31:0] val);
        bus_op(1'b0, addr, 32'd0, val);
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = 32'd0;
        bus.wdata_i = 32'd0;

        // Reset state
        rst = 1'b1;
        cyc(3);
        check("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        cyc(1);
        rdreg(R_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
        rdreg(R_PERIOD, rd); check("rst_period", rd, 32'd0);
        rdreg(R_STATUS, rd); check("rst_status", rd, 32'd0);

        // Register masking and read-only protection
        wr(R_PRE, 32'hFFFF_FFFF);
        rdreg(R_PRE, rd);    check("pre_mask", rd, 32'h0000_FFFF);
        wr(R_PERIOD, 32'h55);
        rdreg(R_PERIOD, rd); check("period_ro", rd, 32'd0);

        // Prescale 0: 100-clock period, 25 high
        wr(R_PRE, 32'd0);
        wr(R_CTRL, 32'd3);
        pwm = 1'b1; cyc(25);
        pwm = 1'b0; cyc(75);
        pwm = 1'b1; cyc(3 + FD);
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        cyc(1);
        check("irq_set", {31'd0, irq}, 32'd1);
        rdreg(R_PERIOD, rd); check("p0_period", rd, 32'd100);
        rdreg(R_HIGH, rd);   check("p0_high", rd, 32'd25);
        rdreg(R_STATUS, rd); check("p0_status", rd, 32'h5);

        // Prescale 3: 400-clock period, 100 high, repeated twice
        pwm = 1'b0;
        wr(R_CTRL, 32'd0);
        wr(R_STATUS, 32'd3);
        wr(R_PRE, 32'd3);
        wr(R_CTRL, 32'd3);
        pwm = 1'b1; cyc(100);
        pwm = 1'b0; cyc(300);
        pwm = 1'b1; cyc(8);
        rdreg(R_PERIOD, rd); check("p3_period_a", rd, 32'd100);
        rdreg(R_HIGH, rd);   check("p3_high_a", rd, 32'd25);
        cyc(88);
        pwm = 1'b0; cyc(300);
        pwm = 1'b1; cyc(8);
        rdreg(R_PERIOD, rd); check("p3_period_b", rd, 32'd100);
        rdreg(R_HIGH, rd);   check("p3_high_b", rd, 32'd25);

        // Overflow of the 8-bit counter, then recovery
        pwm = 1'b0;
        wr(R_CTRL, 32'd0);
        wr(R_PRE, 32'd0);
        wr(R_STATUS, 32'd3);
        wr(R_CTRL, 32'd1);
        pwm = 1'b1; cyc(5);
        pwm = 1'b0; cyc(300);
        rdreg(R_STATUS, rd); check("ovf_status", rd, 32'h2);
        check("ovf_irq_off", {31'd0, irq}, 32'd0);
        pwm = 1'b1; cyc(10);
        rdreg(R_STATUS, rd); check("ovf_rearm", rd, 32'h6);
        cyc(8);
        pwm = 1'b0; cyc(30);
        pwm = 1'b1; cyc(8);
        rdreg(R_PERIOD, rd); check("ovf_period", rd, 32'd50);
        rdreg(R_HIGH, rd);   check("ovf_high", rd, 32'd20);
        rdreg(R_STATUS, rd); check("ovf_status2", rd, 32'h7);

        // W1C on the same edge as a capture: set wins
        pwm = 1'b0;
        wr(R_CTRL, 32'd0);
        wr(R_STATUS, 32'd3);
        wr(R_CTRL, 32'd3);
        pwm = 1'b1; cyc(20);
        pwm = 1'b0; cyc(30);
        pwm = 1'b1;
        cyc(1 + FD);
        bus.valid_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = R_STATUS; bus.wdata_i = 32'd1;
        cyc(1);
        check("coll_ready", {31'd0, bus.ready_o}, 32'd1);
        cyc(1);
        bus.valid_i = 1'b0; bus.we_i = 1'b0;
        cyc(1);
        rdreg(R_STATUS, rd); check("coll_valid", rd, 32'h5);
        check("coll_irq", {31'd0, irq}, 32'd1);
        rdreg(R_PERIOD, rd); check("coll_period", rd, 32'd50);
        wr(R_STATUS, 32'd1);
        rdreg(R_STATUS, rd); check("w1c_status", rd, 32'h4);
        check("w1c_irq", {31'd0, irq}, 32'd0);

        // Bus: unmapped read, single-cycle acknowledge, back-to-back requests
        rdreg(32'h1C, rd);   check("unmapped_rd", rd, 32'd0);
        check("ready_1cyc", {31'd0, bus.ready_o}, 32'd0);
        bus.valid_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = R_CTRL;
        cyc(1); check("b2b_ready0", {31'd0, bus.ready_o}, 32'd1);
        check("b2b_rdata", bus.rdata_o, 32'd3);
        cyc(1); check("b2b_ready1", {31'd0, bus.ready_o}, 32'd0);
        check("b2b_rdata_idle", bus.rdata_o, 32'd0);
        cyc(1); check("b2b_ready2", {31'd0, bus.ready_o}, 32'd1);
        bus.valid_i = 1'b0;
        cyc(1); check("b2b_ready3", {31'd0, bus.ready_o}, 32'd0);

        // Two-clock glitch inside the low phase
        pwm = 1'b0;
        wr(R_CTRL, 32'd0);
        wr(R_STATUS, 32'd3);
        wr(R_CTRL, 32'd3);
        pwm = 1'b1; cyc(20);
        pwm = 1'b0; cyc(15);
        pwm = 1'b1; cyc(2);
        pwm = 1'b0; cyc(5);
        rdreg(R_STATUS, rd);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        check("glitch_status", rd, 32'h0);
`else
        check("glitch_status", rd, 32'h1);
`endif
        cyc(6);
        pwm = 1'b1; cyc(8);
        rdreg(R_PERIOD, rd);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        check("glitch_period", rd, 32'd50);
`else
        check("glitch_period", rd, 32'd15);
`endif
        rdreg(R_HIGH, rd);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        check("glitch_high", rd, 32'd20);
`else
        check("glitch_high", rd, 32'd2);
`endif

        // Reset in the middle of a measurement with a request pending
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        pwm = 1'b0;
        bus.valid_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = R_CTRL;
        rst = 1'b1;
        cyc(1);
        check("mid_rst_ready", {31'd0, bus.ready_o}, 32'd0);
        check("mid_rst_rdata", bus.rdata_o, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        bus.valid_i = 1'b0;
        cyc(1);
        rdreg(R_CTRL, rd);   check("post_rst_ctrl", rd, 32'd0);
        rdreg(R_PERIOD, rd); check("post_rst_period", rd, 32'd0);
        rdreg(R_STATUS, rd); check("post_rst_status", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Wishbone-mapped PWM input capture unit; the receive-side counterpart of the team's PWM generator.
- Samples an external PWM waveform and measures, in prescaled ticks:
  - period: rising edge to rising edge
  - high time: rising edge to falling edge
- Exposes the results through the same valid/ready register interface the PWM generator uses, and raises an interrupt on each completed measurement.
- Instantiated per channel beside the PWM generators, with its input taken from an io_in pad.

Parameters:
- BITS, 32: width of the tick counter and of the PERIOD/HIGH registers (8..32).
- PRESCALE_W, 16: width of the PRESCALE register.

Ports:
- wb_clk_i  input  1  system clock; all logic on the rising edge.
- wb_rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  bus request (cyc & stb, already qualified by channel select).
- ready_o  output  1  bus acknowledge.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address; only addr_i[4:2] is decoded.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data.
- cio_pwm_i  input  1  asynchronous PWM input.
- irq_o  output  1  level interrupt.

Behaviour:
Register map (addr_i[4:2]):
- 0 CTRL (RW): bit0 EN, bit1 IRQ_EN.
- 1 PRESCALE (RW): [PRESCALE_W-1:0]; one tick every PRESCALE+1 clocks.
- 2 PERIOD (RO): last completed period in ticks.
- 3 HIGH (RO): last completed high time in ticks.
- 4 STATUS:
  - bit0 VALID, W1C
  - bit1 OVF, W1C
  - bit2 LEVEL, RO: current synchronized input
- 5..7: read 0; writes ignored.
- Unused register bits read 0.

Bus handshake:
- ready_o is high for exactly one cycle: the cycle after valid_i is sampled high while ready_o is low.
- It is never high on two consecutive cycles.
- rdata_o is valid while ready_o=1 and is 0 otherwise.
- A write commits on the clock edge that ends the ready_o cycle.
- Writes to RO registers are ignored.

Input path:
- cio_pwm_i passes through a 2-flop synchronizer, then one more register for edge detection.
- rise = sync & ~prev; fall = ~sync & prev. Edges are evaluated every clock, not only on ticks.

Prescaler:
- pre_cnt counts 0..PRESCALE and wraps; tick = (pre_cnt == PRESCALE).
- pre_cnt clears on every rise, so measurement phase is aligned to the edge.

State machine (IDLE, ARMED, HIGH_SEEN):
- IDLE: entered on EN=0 or reset. cnt=0. On rise with EN=1 -> ARMED, cnt=0.
- ARMED: cnt increments on each tick.
  - On fall: hi_shadow <= cnt, then -> HIGH_SEEN.
  - On rise before any fall: -> ARMED, cnt=0, no capture (100% duty, treated as a restart).
- HIGH_SEEN: cnt continues to increment.
  - On rise: PERIOD <= cnt, HIGH <= hi_shadow, VALID <= 1, cnt=0, -> ARMED.
- Overflow: if a tick arrives with cnt all-ones, OVF <= 1, cnt holds and the state goes to IDLE. The next rise re-arms; nothing is captured from the overflowed cycle.
- Writing EN 1->0: state -> IDLE, cnt and pre_cnt cleared. PERIOD, HIGH and STATUS are retained.

Flags and interrupt:
- VALID/OVF: a hardware set and a W1C in the same cycle -> the set wins (flag stays 1).
- VALID is not blocked by an unread previous result; PERIOD/HIGH are overwritten (latest wins).
- irq_o = IRQ_EN & (VALID | OVF), registered (one cycle after the flag sets).

Reset (wb_rst_i=1 at a clock edge, including mid-measurement):
- All registers go to 0, state -> IDLE.
- ready_o=0, rdata_o=0, irq_o=0.
- Synchronizer flops go to 0, so an input that is high at reset release does not produce a rise.

Optional Feature:
- Macro: PWM_CAPTURE_GLITCH_FILTER_EN
- Defined: a 3-bit shift register follows the synchronizer. The filtered level changes only when 4 consecutive samples agree. Pulses shorter than 4 clocks are ignored, and edges are delayed by 3 further clocks; measured widths are unchanged because both edges see the same delay.
- Undefined: no filter; the synchronizer output is used directly. STATUS.LEVEL always reflects the signal the edge detector uses.

Test Plan:
- Prescale 0, EN=1: input period 100 clocks, 25 high -> after the 2nd rise, VALID=1, PERIOD=100, HIGH=25; with IRQ_EN=1, irq_o=1 one cycle later.
- PRESCALE=3: period 400 clocks, 100 high -> PERIOD=100, HIGH=25; repeated cycles give identical values.
- BITS=8, PRESCALE=0: input held low for 300 clocks after a rise -> OVF=1, VALID=0, state IDLE. A following 50/20 waveform -> PERIOD=50 on the 2nd subsequent rise.
- Write STATUS=0x1 on the same cycle a capture sets VALID -> VALID stays 1. A W1C on a later, quiet cycle -> VALID=0 and irq_o drops.
- Bus: read from addr 0x1C -> ready_o for 1 cycle, rdata_o=0. Back-to-back valid_i held high -> ready_o alternates 1,0,1.
- Filter macro defined: 2-clock glitch inside the low phase -> no capture, PERIOD unchanged. Macro undefined: same stimulus causes a restart and a capture of a short period. Assert wb_rst_i mid-measurement -> all outputs 0 the next cycle.
